// File: rtl/tnet_pkg.sv
// rtl/tnet_pkg.sv - tnet header field layout, arbiter state type and header stamping helper
package tnet_pkg;

   localparam int TNET_W  = 64;
   localparam int FLAGS_HI = 55;
   localparam int FLAGS_LO = 50;
   localparam int DST_HI   = 49;
   localparam int DST_LO   = 40;
   localparam int SRC_HI   = 39;
   localparam int SRC_LO   = 30;
   localparam int STEP_HI  = 29;
   localparam int STEP_LO  = 20;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SEND    = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_st_t;

   // Source field takes our node ID, step restarts at zero; everything else passes through.
   function automatic logic [TNET_W-1:0] stamp_hdr(input logic [TNET_W-1:0] hdr,
                                                   input logic [SRC_HI-SRC_LO:0] id);
      return {hdr[TNET_W-1:FLAGS_HI+1], hdr[FLAGS_HI:FLAGS_LO], hdr[DST_HI:DST_LO],
              id, {(STEP_HI-STEP_LO+1){1'b0}}, hdr[STEP_LO-1:0]};
   endfunction

endpackage

// File: rtl/tnet_tx_arbiter_if.sv
// rtl/tnet_tx_arbiter_if.sv - tnet TX request port (4-phase req/ack with header and data)
interface tnet_tx_arbiter_if;
   import tnet_pkg::*;

   logic              tx_req;
   logic [TNET_W-1:0] tx_header;
   logic [TNET_W-1:0] tx_data;
   logic              tx_ack;

   modport master (output tx_req, output tx_header, output tx_data, input tx_ack);
   modport slave  (input tx_req, input tx_header, input tx_data, output tx_ack);

endinterface

// File: rtl/tnet_tx_arbiter_rr_pick.sv
// rtl/tnet_tx_arbiter_rr_pick.sv - combinational round-robin select: first set request at/after ptr
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic            valid_o,
   output logic [IW-1:0]   idx_o
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [IW:0]       sum;

   assign dbl = {req_i, req_i};
   assign rot = NREQ'(dbl >> ptr_i);

   // Walk from the far end so the closest request to ptr is written last and wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid_o = 1'b1;
            sum     = {1'b0, ptr_i} + (IW+1)'(i);
            idx_o   = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
         end
      end
   end

endmodule

// File: rtl/tnet_tx_arbiter.sv
// rtl/tnet_tx_arbiter.sv - round-robin arbiter onto the single tnet TX port
// Optional SEND timeout with sticky per-requester error: define TNET_ARB_TIMEOUT_EN.
module tnet_tx_arbiter
   import tnet_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TMO_CYC = 1024
) (
   input  logic                         user_clk_i,
   input  logic                         user_rst_i,
   input  logic [9:0]                   ID,
   input  logic                         ready_i,
   input  logic [NREQ-1:0]              req_i,
   input  logic [NREQ-1:0][TNET_W-1:0]  header_i,
   input  logic [NREQ-1:0][TNET_W-1:0]  data_i,
   output logic [NREQ-1:0]              ack_o,
   output logic [NREQ-1:0]              err_o,
   tnet_tx_arbiter_if.master            tx,
   output logic [2:0]                   grant_o,
   output logic                         busy_o,
   output logic [31:0]                  tx_cnt_o
);

   localparam int IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_param
      $error("tnet_tx_arbiter: NREQ must be 2..8 and TMO_CYC 1..65535");
   end

   arb_st_t           state_q;
   logic [IW-1:0]     ptr_q;
   logic [IW-1:0]     grant_q;
   logic [TNET_W-1:0] hdr_q;
   logic [TNET_W-1:0] data_q;
   logic              tx_req_q;
   logic [NREQ-1:0]   ack_q;
   logic [31:0]       cnt_q;

   logic              pick_valid;
   logic [IW-1:0]     pick_idx;
   logic [IW-1:0]     ptr_d;
   logic [TNET_W-1:0] hdr_d;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign hdr_d = stamp_hdr(header_i[pick_idx], ID);
   assign ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef TNET_ARB_TIMEOUT_EN
   logic [15:0]     tmo_q;
   logic [NREQ-1:0] err_q;
   assign err_o = err_q;
`else
   assign err_o = '0;
`endif

   always_ff @(posedge user_clk_i) begin
      if (user_rst_i) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         hdr_q    <= '0;
         data_q   <= '0;
         tx_req_q <= 1'b0;
         ack_q    <= '0;
         cnt_q    <= '0;
`ifdef TNET_ARB_TIMEOUT_EN
         tmo_q    <= '0;
         err_q    <= '0;
`endif
      end else begin
         case (state_q)
            ARB_IDLE: begin
               // A lingering tx_ack from the previous handshake blocks a new grant.
               if (ready_i && pick_valid && !tx.tx_ack) begin
                  grant_q  <= pick_idx;
                  hdr_q    <= hdr_d;
                  data_q   <= data_i[pick_idx];
                  tx_req_q <= 1'b1;
                  state_q  <= ARB_SEND;
`ifdef TNET_ARB_TIMEOUT_EN
                  tmo_q           <= '0;
                  err_q[pick_idx] <= 1'b0;
`endif
               end
            end
            ARB_SEND: begin
               if (tx.tx_ack) begin
                  tx_req_q       <= 1'b0;
                  ack_q[grant_q] <= 1'b1;
                  cnt_q          <= cnt_q + 32'd1;
                  state_q        <= ARB_RELEASE;
               end
`ifdef TNET_ARB_TIMEOUT_EN
               else if (tmo_q == 16'(TMO_CYC - 1)) begin
                  tx_req_q       <= 1'b0;
                  ack_q[grant_q] <= 1'b1;
                  err_q[grant_q] <= 1'b1;
                  state_q        <= ARB_RELEASE;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
`endif
            end
            ARB_RELEASE: begin
               if (!tx.tx_ack && !req_i[grant_q]) begin
                  ack_q   <= '0;
                  ptr_q   <= ptr_d;
                  state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign tx.tx_req    = tx_req_q;
   assign tx.tx_header = hdr_q;
   assign tx.tx_data   = data_q;
   assign ack_o        = ack_q;
   assign grant_o      = 3'(grant_q);
   assign busy_o       = (state_q != ARB_IDLE);
   assign tx_cnt_o     = cnt_q;

endmodule

// File: tb/tb_tnet_tx_arbiter.sv
// tb/tb_tnet_tx_arbiter.sv - randomized self-checking bench for tnet_tx_arbiter against a transaction-level model
module tb_tnet_tx_arbiter;
   import tnet_pkg::*;

   localparam int NREQ = 4;
   localparam int TMO  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0]                  id    = '0;
   logic                        ready = 1'b0;
   logic [NREQ-1:0]             req   = '0;
   logic [NREQ-1:0][TNET_W-1:0] hdr   = '0;
   logic [NREQ-1:0][TNET_W-1:0] dat   = '0;
   logic [NREQ-1:0]             ack;
   logic [NREQ-1:0]             err;
   logic [2:0]                  grant;
   logic                        busy;
   logic [31:0]                 cnt;

   tnet_tx_arbiter_if tx_if ();

   tnet_tx_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
      .user_clk_i (clk),
      .user_rst_i (rst),
      .ID         (id),
      .ready_i    (ready),
      .req_i      (req),
      .header_i   (hdr),
      .data_i     (dat),
      .ack_o      (ack),
      .err_o      (err),
      .tx         (tx_if),
      .grant_o    (grant),
      .busy_o     (busy),
      .tx_cnt_o   (cnt)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          ptr_m = 0;
   logic [31:0] cnt_m = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: first requester at or after the pointer, scanning cyclically.
   function automatic int exp_winner(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return 0;
   endfunction

   function automatic logic [63:0] exp_header(input logic [63:0] h, input logic [9:0] i);
      logic [63:0] clr;
      clr = 64'h0000_00FF_FFF0_0000;
      return (h & ~clr) | (64'(i) << 30);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_txreq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (tx_if.tx_req) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) check("txreq_wait", 64'd0, 64'd1);
   endtask

   task automatic xfer(input int ack_dly, input bit drop_early, input bit rearm);
      int          w;
      bit          ok;
      logic [63:0] eh;
      logic [63:0] ed;
      w  = exp_winner(req, ptr_m);
      eh = exp_header(hdr[w], id);
      ed = dat[w];
      wait_txreq(ok);
      if (!ok) return;
      check("grant", 64'(grant), 64'(w));
      check("hdr", tx_if.tx_header, eh);
      check("data", tx_if.tx_data, ed);
      hdr[w] = {$urandom, $urandom};
      dat[w] = {$urandom, $urandom};
      if (drop_early) req[w] = 1'b0;
      for (int i = 0; i < ack_dly; i++) begin
         step();
         ready = 1'($urandom % 2);
      end
      check("txreq_held", 64'(tx_if.tx_req), 64'd1);
      check("hdr_hold", tx_if.tx_header, eh);
      check("data_hold", tx_if.tx_data, ed);
      check("ack_early", 64'(ack), 64'd0);
      tx_if.tx_ack = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack_seen", 64'(ok), 64'd1);
      check("ack_vec", 64'(ack), 64'd1 << w);
      check("txreq_drop", 64'(tx_if.tx_req), 64'd0);
      cnt_m = cnt_m + 32'd1;
      check("tx_cnt", 64'(cnt), 64'(cnt_m));
      req[w] = 1'b0;
      tx_if.tx_ack = 1'b0;
      ready = 1'b1;
      step();
      check("ack_release", 64'(ack), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      ptr_m = (w + 1) % NREQ;
      if (rearm) req[w] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (!rst && ack != '0) check("ack_onehot", 64'($onehot(ack)), 64'd1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      int          n;
      logic [NREQ-1:0] newm;
      tx_if.tx_ack = 1'b0;

      repeat (3) step();
      check("rst_txreq", 64'(tx_if.tx_req), 64'd0);
      check("rst_hdr", tx_if.tx_header, 64'd0);
      check("rst_data", tx_if.tx_data, 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cnt", 64'(cnt), 64'd0);
      rst = 1'b0;
      step();

      // Single requester with the documented header and ID.
      id     = 10'd5;
      ready  = 1'b1;
      hdr[1] = 64'h00FF_3FF0_0000_1234;
      dat[1] = 64'hDEAD_BEEF_0BAD_F00D;
      req    = 4'b0010;
      xfer(2, 1'b0, 1'b0);

      // ready low holds off the grant.
      ready = 1'b0;
      req   = 4'b0100;
      repeat (5) step();
      check("notready_txreq", 64'(tx_if.tx_req), 64'd0);
      check("notready_busy", 64'(busy), 64'd0);
      ready = 1'b1;
      step();
      check("ready_txreq", 64'(tx_if.tx_req), 64'd1);
      xfer(1, 1'b0, 1'b0);

      // All requesters held from a fresh reset: strict rotation.
      rst = 1'b1;
      step();
      rst = 1'b0;
      ptr_m = 0;
      cnt_m = '0;
      for (int j = 0; j < NREQ; j++) begin
         hdr[j] = {$urandom, $urandom};
         dat[j] = {$urandom, $urandom};
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) xfer(0, 1'b0, 1'b1);
      req = '0;

      // Long ack delay while the requester scribbles on its payload.
      hdr[3] = {$urandom, $urandom};
      dat[3] = {$urandom, $urandom};
      req[3] = 1'b1;
      xfer(50, 1'b0, 1'b0);

      for (int it = 0; it < 40; it++) begin
         id   = 10'($urandom);
         newm = NREQ'($urandom);
         if ((req | newm) == '0) newm[$urandom % NREQ] = 1'b1;
         for (int j = 0; j < NREQ; j++) begin
            if (newm[j] && !req[j]) begin
               hdr[j] = {$urandom, $urandom};
               dat[j] = {$urandom, $urandom};
            end
         end
         req   = req | newm;
         ready = 1'b0;
         n = $urandom_range(1, 3);
         repeat (n) step();
         check("rnd_notready", 64'(tx_if.tx_req), 64'd0);
         ready = 1'b1;
         xfer($urandom_range(0, 6), 1'($urandom % 2), 1'b0);
      end

      // Reset in the middle of SEND.
      if (req == '0) begin
         hdr[3] = {$urandom, $urandom};
         req[3] = 1'b1;
      end
      wait_txreq(ok);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      step();
      check("midrst_txreq", 64'(tx_if.tx_req), 64'd0);
      check("midrst_ack", 64'(ack), 64'd0);
      check("midrst_grant", 64'(grant), 64'd0);
      check("midrst_cnt", 64'(cnt), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      req   = '0;
      rst   = 1'b0;
      ptr_m = 0;
      cnt_m = '0;
      step();

`ifdef TNET_ARB_TIMEOUT_EN
      req = 4'b0010;
      wait_txreq(ok);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!tx_if.tx_req) break;
         n++;
      end
      check("tmo_len", 64'(n), 64'(TMO));
      check("tmo_err", 64'(err), 64'd2);
      check("tmo_ack", 64'(ack), 64'd2);
      check("tmo_cnt", 64'(cnt), 64'(cnt_m));
      req = '0;
      step();
      check("tmo_ack_release", 64'(ack), 64'd0);
      ptr_m = 2;
      req[1] = 1'b1;
      wait_txreq(ok);
      check("tmo_err_clear", 64'(err), 64'd0);
      xfer(0, 1'b0, 1'b0);
`else
      check("err_tied", 64'(err), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
